// File: rtl/uart_seq_tx_if.sv
// Valid/ready write port that feeds bytes into the uart_seq_tx queue.
interface uart_seq_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_seq_tx.sv
// Buffered UART transmitter: a FIFO of queued words serialised back-to-back
// as start / data (LSB first) / optional parity / stop frames on uart_txd.
module uart_seq_tx #(
    parameter int MAIN_FRE   = 100,
    parameter int BAUD       = 115200,
    parameter int CLK_DIV    = MAIN_FRE * 1000000 / BAUD,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    uart_seq_tx_if.slave                  wr,
    output logic                          uart_txd,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_d;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          level_q;

    logic push, pop, bit_end, fifo_nempty;

    assign wr.tx_ready = (level_q != (AW + 1)'(FIFO_DEPTH));
    assign push        = wr.tx_valid && wr.tx_ready;
    assign fifo_nempty = (level_q != '0);
    assign bit_end     = (cnt_q == CW'(CLK_DIV - 1));
    assign busy        = (state_q != IDLE);
    assign fifo_level  = level_q;

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement leaves a variable unassigned and a latch is inferred.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (bit_end && bit_q == 4'(STOP_BITS - 1)) begin
                    tx_done = 1'b1;
                    // Chain straight into the next frame so the line has no idle gap.
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = mem[rd_ptr];
            par_d   = (^mem[rd_ptr]) ^ (PARITY == 1);
            bit_d   = '0;
        end

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PAR:     txd_d = par_q;
            default: txd_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            uart_txd <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            uart_txd <= txd_d;

            if (state_q == IDLE || bit_end || pop) cnt_q <= '0;
            else                                   cnt_q <= cnt_q + CW'(1);

            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and level
    // define which entries are valid, and a resettable array costs a mux per bit.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= wr.tx_data;
    end

endmodule

// File: tb/tb_uart_seq_tx.sv
// Self-checking bench for uart_seq_tx: a frame-timeline model checks the 8N1
// instance every cycle; three side instances cover parity and frame shape.
module tb_uart_seq_tx;

    localparam int CDIV  = 4;
    localparam int DEPTH = 8;
    localparam int FL    = 10 * CDIV;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Line level of bit slot k of a frame carrying word b.
    function automatic logic frame_bit(input logic [8:0] b, input int nd, input int par, input int k);
        logic [8:0] m;
        if (k == 0) return 1'b0;
        if (k <= nd) return b[k-1];
        if (par != 0 && k == nd + 1) begin
            m = b & ((9'd1 << nd) - 9'd1);
            return (^m) ^ (par == 1);
        end
        return 1'b1;
    endfunction

    // Main 8N1 instance.
    uart_seq_tx_if #(.DATA_BITS(8)) a_if ();
    logic       a_txd, a_busy, a_done;
    logic [3:0] a_level;

    uart_seq_tx #(
        .CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .wr(a_if),
        .uart_txd(a_txd), .busy(a_busy), .tx_done(a_done), .fifo_level(a_level)
    );

    // Reference model: a queue of waiting words plus the timeline of the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] m_byte = '0;
    bit         m_act = 0;
    bit         m_ok = 0;
    bit         m_push;
    int         m_ft = 0;

    always @(negedge sys_clk) begin
        if (m_ok) begin
            check("txd", a_txd, m_act ? frame_bit({1'b0, m_byte}, 8, 0, m_ft / CDIV) : 1'b1);
            check("busy", a_busy, m_act);
            check("tx_done", a_done, m_act && m_ft == FL - 1);
            check("level", a_level, mq.size());
            check("ready", a_if.tx_ready, mq.size() != DEPTH);
        end
        if (sys_rst !== 1'b1) begin
            mq.delete();
            m_act = 0;
            m_ok  = 1;
        end else if (m_ok) begin
            m_push = (a_if.tx_valid === 1'b1) && (mq.size() != DEPTH);
            if ((!m_act || m_ft == FL - 1) && mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_act  = 1;
                m_ft   = 0;
            end else if (m_act) begin
                if (m_ft == FL - 1) m_act = 0;
                else m_ft++;
            end
            if (m_push) mq.push_back(a_if.tx_data);
        end
    end

    // Independent line receiver: detects start bits and samples at bit centres.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = '0;
    bit         rx_on = 0;
    int         rx_t = 0;

    always @(negedge sys_clk) begin
        if (sys_rst !== 1'b1) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (a_txd === 1'b0) begin
                rx_on = 1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CDIV == CDIV / 2) begin
                if (rx_t / CDIV <= 8) begin
                    rx_sh[rx_t / CDIV - 1] = a_txd;
                end else begin
                    check("rx_stop", a_txd, 1'b1);
                    rx_q.push_back(rx_sh);
                    rx_on = 0;
                end
            end
        end
    end

    // Activity monitor for the directed timing expectations.
    int mon_busy, mon_done, mon_rise, first_low, last_busy;
    bit prev_busy = 0;

    always @(negedge sys_clk) begin
        if (a_busy === 1'b1) begin
            mon_busy++;
            last_busy = cyc;
            if (!prev_busy) mon_rise++;
        end
        if (a_done === 1'b1) mon_done++;
        if (a_txd === 1'b0 && first_low < 0) first_low = cyc;
        prev_busy = (a_busy === 1'b1);
    end

    task automatic mon_clear();
        mon_busy = 0; mon_done = 0; mon_rise = 0; first_low = -1; last_busy = -1;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 * FL; i++) begin
            if (a_done === 1'b1) break;
            step();
        end
        check(name, a_done, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 * FL; i++) begin
            if (a_busy === 1'b0 && a_level === 4'd0) break;
            step();
        end
        check(name, {a_busy, a_level}, 5'd0);
        repeat (4) step();
    endtask

    // Side instances: even parity, odd parity, 7-bit with two stop bits.
    bit g_done [3];

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int         DB      = (g == 2) ? 7 : 8;
        localparam int         PM      = (g == 0) ? 2 : (g == 1) ? 1 : 0;
        localparam int         SB      = (g == 2) ? 2 : 1;
        localparam int         NB      = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
        localparam logic [8:0] BYTE    = (g == 2) ? 9'h055 : 9'h04B;
        localparam logic [10:0] LIT    = (g == 0) ? 11'h496 : (g == 1) ? 11'h696 : 11'h3AA;
        localparam int         LEN_LIT = (g == 2) ? 40 : 44;

        uart_seq_tx_if #(.DATA_BITS(DB)) c_if ();
        logic       c_txd, c_busy, c_done;
        logic [3:0] c_level;

        uart_seq_tx #(
            .CLK_DIV(CDIV), .DATA_BITS(DB), .PARITY(PM), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
        ) dut (
            .sys_clk(sys_clk), .sys_rst(sys_rst), .wr(c_if),
            .uart_txd(c_txd), .busy(c_busy), .tx_done(c_done), .fifo_level(c_level)
        );

        initial begin
            logic [8:0]  bv;
            logic [10:0] bits;
            int          busy_n, done_n, f;
            bv = BYTE; bits = '0; busy_n = 0; done_n = 0; g_done[g] = 0;
            c_if.tx_valid = 1'b0;
            c_if.tx_data  = '0;
            wait (sys_rst === 1'b1);
            @(posedge sys_clk); #1;
            c_if.tx_valid = 1'b1;
            c_if.tx_data  = bv[DB-1:0];
            @(posedge sys_clk); #1;
            c_if.tx_valid = 1'b0;
            for (int c = 0; c <= NB * CDIV + 4; c++) begin
                @(negedge sys_clk);
                f = c - 1;
                check($sformatf("cfg%0d_txd", g), c_txd,
                      (f >= 0 && f < NB * CDIV) ? frame_bit(BYTE, DB, PM, f / CDIV) : 1'b1);
                if (c_busy === 1'b1) busy_n++;
                if (c_done === 1'b1) begin
                    done_n++;
                    check($sformatf("cfg%0d_done_pos", g), f, NB * CDIV - 1);
                end
                if (f >= 0 && f % CDIV == CDIV / 2 && f / CDIV < 11) bits[f / CDIV] = c_txd;
            end
            check($sformatf("cfg%0d_bits", g), bits & 11'((1 << NB) - 1), LIT);
            check($sformatf("cfg%0d_len", g), busy_n, LEN_LIT);
            check($sformatf("cfg%0d_pulses", g), done_n, 1);
            g_done[g] = 1;
        end
    end

    logic [7:0] seq [6] = '{8'h4B, 8'h4C, 8'h66, 8'h2E, 8'h66, 8'h32};
    logic [7:0] sim_exp [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
    int         w0, acc, rise;
    int         pct [4] = '{5, 30, 90, 50};

    initial begin
        a_if.tx_valid = 1'b0;
        a_if.tx_data  = '0;
        mon_clear();
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_txd", a_txd, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_level", a_level, 4'd0);
        check("rst_ready", a_if.tx_ready, 1'b1);
        sys_rst = 1'b1;
        step();

        // Six consecutive writes: contiguous frames, one busy run.
        mon_clear();
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            a_if.tx_valid = 1'b1;
            a_if.tx_data  = seq[i];
            step();
            if (i == 0) w0 = cyc;
        end
        a_if.tx_valid = 1'b0;
        repeat (260) step();
        check("seq_start_latency", first_low - w0, 1);
        check("seq_busy_cycles", mon_busy, 6 * FL);
        check("seq_busy_runs", mon_rise, 1);
        check("seq_last_busy", last_busy - w0, 240);
        check("seq_done_pulses", mon_done, 6);
        check("seq_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("seq_rx%0d", i), rx_q[i], seq[i]);

        // FIFO full: valid held with incrementing data for 12 cycles.
        rx_q.delete();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            a_if.tx_valid = 1'b1;
            a_if.tx_data  = 8'(i);
            if (a_if.tx_ready === 1'b1) acc++;
            step();
            if (i == 0) w0 = cyc;
        end
        a_if.tx_valid = 1'b0;
        check("full_accepts", acc, 9);
        check("full_level", a_level, 4'd8);
        check("full_ready", a_if.tx_ready, 1'b0);
        rise = -1;
        for (int i = 0; i < 3 * FL; i++) begin
            if (a_if.tx_ready === 1'b1) begin
                rise = cyc;
                break;
            end
            step();
        end
        check("full_ready_rise", rise - w0, 41);
        wait_idle("full_drain");
        check("full_rx_count", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) check($sformatf("full_rx%0d", i), rx_q[i], 8'(i));

        // Write on the same edge as a back-to-back pop.
        rx_q.delete();
        for (int i = 0; i < 4; i++) begin
            a_if.tx_valid = 1'b1;
            a_if.tx_data  = sim_exp[i];
            step();
        end
        a_if.tx_valid = 1'b0;
        check("sim_level_pre", a_level, 4'd3);
        wait_done("sim_done_seen");
        a_if.tx_valid = 1'b1;
        a_if.tx_data  = 8'hA5;
        step();
        a_if.tx_valid = 1'b0;
        check("sim_level", a_level, 4'd3);
        wait_idle("sim_drain");
        check("sim_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("sim_rx%0d", i), rx_q[i], sim_exp[i]);

        // Reset during data bit 3 of the second of three queued frames.
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            a_if.tx_valid = 1'b1;
            a_if.tx_data  = 8'hC1 + 8'(i);
            step();
        end
        a_if.tx_valid = 1'b0;
        wait_done("rst_first_done");
        repeat (17) step();
        sys_rst = 1'b0;
        step();
        sys_rst = 1'b1;
        mon_clear();
        check("midrst_txd", a_txd, 1'b1);
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_level", a_level, 4'd0);
        repeat (200) step();
        check("midrst_no_done", mon_done, 0);
        check("midrst_no_busy", mon_busy, 0);
        check("midrst_rx_count", rx_q.size(), 1);
        check("midrst_rx0", rx_q[0], 8'hC1);

        // Randomised traffic at several densities, checked every cycle by the model.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 400; i++) begin
                a_if.tx_valid = ($urandom_range(0, 99) < pct[ph]);
                a_if.tx_data  = 8'($urandom);
                step();
            end
        end
        a_if.tx_valid = 1'b0;
        wait_idle("rand_drain");

        for (int i = 0; i < 1000; i++) begin
            if (g_done[0] && g_done[1] && g_done[2]) break;
            step();
        end
        check("cfg_finished", {g_done[0], g_done[1], g_done[2]}, 3'b111);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
